hazard_sb: RTL and testbench

HAZARD_SB -- requirements
Module: hazard_sb

---
 rtl/hazard_sb.sv | 122 ++++++++++++
 tb/tb_hazard_sb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_sb.sv
// Pipeline hazard unit: forwarding, stall/flush generation and a MUL/DIV register scoreboard.
// Stall/flush/forward outputs are combinational; Pending, StallCount and StallTimeout lag their cause by one cycle.
module hazard_sb #(
   parameter int NREG  = 16,
   parameter int RA_W  = 4,
   parameter int TMO   = 255,
   parameter int CNT_W = 16
) (
   input  logic              CLK,
   input  logic              RESETn,
   input  logic [RA_W-1:0]   RA1D,
   input  logic [RA_W-1:0]   RA2D,
   input  logic [RA_W-1:0]   WA3D,
   input  logic              RegWriteD,
   input  logic              McD,
   input  logic [RA_W-1:0]   RA1E,
   input  logic [RA_W-1:0]   RA2E,
   input  logic [RA_W-1:0]   WA3E,
   input  logic              RegWriteE,
   input  logic              MemtoRegE,
   input  logic              PCSrcE,
   input  logic              McStartE,
   input  logic [RA_W-1:0]   WA3M,
   input  logic              RegWriteM,
   input  logic              MemtoRegM,
   input  logic              MemWriteM,
   input  logic              cache_ready,
   input  logic [RA_W-1:0]   WA3W,
   input  logic              RegWriteW,
   input  logic              McDoneW,
   input  logic [RA_W-1:0]   McWA3W,
   input  logic              McBusy,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              StallM,
   output logic              FlushD,
   output logic              FlushE,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic [NREG-1:0]   Pending,
   output logic [CNT_W-1:0]  StallCount,
   output logic              StallTimeout
);

   localparam int RUN_W  = (TMO < 2) ? 1 : $clog2(TMO + 1);
   localparam int NADDR  = 2 ** RA_W;

   logic [NREG-1:0]  pending_q, pending_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             timeout_q, timeout_d;
   logic [NADDR-1:0] pend_ext;
   logic             ld_use, cache_stall, scb_stall, mc_stall, stall_any, issue;

   always_comb begin
      ForwardAE = 2'b00;
      if (RegWriteM && (RA1E == WA3M))      ForwardAE = 2'b10;
      else if (RegWriteW && (RA1E == WA3W)) ForwardAE = 2'b01;
      ForwardBE = 2'b00;
      if (RegWriteM && (RA2E == WA3M))      ForwardBE = 2'b10;
      else if (RegWriteW && (RA2E == WA3W)) ForwardBE = 2'b01;
   end

   // Addresses beyond NREG land in the zero-filled upper part and read as idle.
   always_comb begin
      pend_ext = '0;
      pend_ext[NREG-1:0] = pending_q;
   end

   always_comb begin
      ld_use      = ((RA1D == WA3E) || (RA2D == WA3E)) && MemtoRegE && RegWriteE;
      cache_stall = (MemtoRegM || MemWriteM) && !cache_ready;
      scb_stall   = pend_ext[RA1D] || pend_ext[RA2D] || (RegWriteD && pend_ext[WA3D]);
      mc_stall    = McD && (McBusy || McStartE);
      stall_any   = ld_use || cache_stall || scb_stall || mc_stall;
      issue       = McStartE && RegWriteE && !cache_stall && !PCSrcE;
   end

   assign StallF = stall_any;
   assign StallD = stall_any;
   assign StallE = cache_stall;
   assign StallM = cache_stall;
   assign FlushD = PCSrcE;
   assign FlushE = (ld_use || scb_stall || mc_stall) && !cache_stall;

   // Clear is applied before set so a same-register collision leaves the entry pending.
   always_comb begin
      pending_d = pending_q;
      for (int i = 0; i < NREG; i++) begin
         if (McDoneW && (McWA3W == RA_W'(i))) pending_d[i] = 1'b0;
         if (issue && (WA3E == RA_W'(i)))     pending_d[i] = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_any && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      run_d = '0;
      if (stall_any) run_d = (run_q == RUN_W'(TMO)) ? run_q : run_q + RUN_W'(1);
      timeout_d = timeout_q || (run_d == RUN_W'(TMO));
   end

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         pending_q   <= '0;
         stall_cnt_q <= '0;
         run_q       <= '0;
         timeout_q   <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         stall_cnt_q <= stall_cnt_d;
         run_q       <= run_d;
         timeout_q   <= timeout_d;
      end
   end

   assign Pending      = pending_q;
   assign StallCount   = stall_cnt_q;
   assign StallTimeout = timeout_q;

endmodule

// File: tb/tb_hazard_sb.sv
// Directed bench for hazard_sb: NREG=12 exercises out-of-range addresses, CNT_W=5 exercises saturation.
module tb_hazard_sb;

   localparam int NREG  = 12;
   localparam int RA_W  = 4;
   localparam int TMO   = 8;
   localparam int CNT_W = 5;

   logic CLK = 1'b0;
   logic RESETn;
   logic [RA_W-1:0] RA1D, RA2D, WA3D, RA1E, RA2E, WA3E, WA3M, WA3W, McWA3W;
   logic RegWriteD, McD, RegWriteE, MemtoRegE, PCSrcE, McStartE;
   logic RegWriteM, MemtoRegM, MemWriteM, cache_ready, RegWriteW, McDoneW, McBusy;
   logic StallF, StallD, StallE, StallM, FlushD, FlushE, StallTimeout;
   logic [1:0] ForwardAE, ForwardBE;
   logic [NREG-1:0] Pending;
   logic [CNT_W-1:0] StallCount;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   hazard_sb #(.NREG(NREG), .RA_W(RA_W), .TMO(TMO), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RESETn(RESETn),
      .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D), .RegWriteD(RegWriteD), .McD(McD),
      .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
      .PCSrcE(PCSrcE), .McStartE(McStartE),
      .WA3M(WA3M), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
      .cache_ready(cache_ready), .WA3W(WA3W), .RegWriteW(RegWriteW),
      .McDoneW(McDoneW), .McWA3W(McWA3W), .McBusy(McBusy),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .Pending(Pending), .StallCount(StallCount), .StallTimeout(StallTimeout)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_idle();
      RA1D = '0; RA2D = '0; WA3D = '0; RegWriteD = 0; McD = 0;
      RA1E = '0; RA2E = '0; WA3E = '0; RegWriteE = 0; MemtoRegE = 0; PCSrcE = 0; McStartE = 0;
      WA3M = '0; RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0; cache_ready = 1;
      WA3W = '0; RegWriteW = 0; McDoneW = 0; McWA3W = '0; McBusy = 0;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic [RA_W-1:0] r);
      McStartE = 1; RegWriteE = 1; WA3E = r;
   endtask

   task automatic cache_miss(input int n);
      MemtoRegM = 1; cache_ready = 0;
      for (int i = 0; i < n; i++) tick();
      MemtoRegM = 0; cache_ready = 1;
   endtask

   initial begin
      RESETn = 0;
      set_idle();
      tick(); tick();
      RESETn = 1;
      #1;
      check_eq("rst_pending", Pending, 0);
      check_eq("rst_count", StallCount, 0);
      check_eq("rst_timeout", StallTimeout, 0);
      check_eq("rst_stall", {StallF, StallD, StallE, StallM, FlushD, FlushE}, 0);
      check_eq("rst_fwd", {ForwardAE, ForwardBE}, 0);

      // Forwarding priority
      RA1E = 3; RA2E = 3; WA3M = 3; RegWriteM = 1; WA3W = 3; RegWriteW = 1; #1;
      check_eq("fwd_a_m", ForwardAE, 2'b10);
      check_eq("fwd_b_m", ForwardBE, 2'b10);
      RegWriteM = 0; #1;
      check_eq("fwd_a_w", ForwardAE, 2'b01);
      RA2E = 4; #1;
      check_eq("fwd_b_rf", ForwardBE, 2'b00);
      set_idle();

      // Scoreboard RAW
      issue(5); #1;
      check_eq("raw_issue_nostall", StallF, 0);
      tick();
      set_idle(); #1;
      check_eq("raw_pending", Pending, 12'h020);
      RA1D = 5; McDoneW = 1; McWA3W = 5; #1;
      check_eq("raw_stalld", StallD, 1);
      check_eq("raw_flushe", FlushE, 1);
      check_eq("raw_stalle", StallE, 0);
      tick();
      McDoneW = 0; #1;
      check_eq("raw_cleared", Pending, 12'h000);
      check_eq("raw_release", StallD, 0);
      check_eq("raw_count", StallCount, 1);
      set_idle();

      // Same-cycle set and clear
      issue(2); tick();
      issue(7); McDoneW = 1; McWA3W = 7; tick();
      check_eq("sc_same", Pending, 12'h084);
      issue(7); McWA3W = 2; tick();
      check_eq("sc_diff", Pending, 12'h080);
      set_idle();

      // Out-of-range address, WAW, MUL/DIV stall, flush-gated issue
      issue(13); tick();
      set_idle(); #1;
      check_eq("oor_set", Pending, 12'h080);
      RA1D = 13; #1;
      check_eq("oor_read", StallD, 0);
      RA1D = 0; RegWriteD = 1; WA3D = 7; #1;
      check_eq("waw_stall", StallF, 1);
      RegWriteD = 0; McD = 1; McBusy = 1; #1;
      check_eq("mc_stall", {StallF, FlushE}, 2'b11);
      McBusy = 0; #1;
      check_eq("mc_idle", StallF, 0);
      McD = 0; issue(9); PCSrcE = 1; #1;
      check_eq("flushd", FlushD, 1);
      tick();
      set_idle(); McDoneW = 1; McWA3W = 7; #1;
      check_eq("flush_noissue", Pending, 12'h080);
      tick();
      set_idle(); #1;
      check_eq("clear_r7", Pending, 12'h000);
      check_eq("count_before_miss", StallCount, 1);

      // Cache miss overlapping load-use
      RA1D = 4; WA3E = 4; MemtoRegE = 1; RegWriteE = 1; MemtoRegM = 1; cache_ready = 0; #1;
      check_eq("miss_stalls", {StallF, StallD, StallE, StallM}, 4'hF);
      check_eq("miss_flushe", FlushE, 0);
      cache_miss(4);
      set_idle(); #1;
      check_eq("miss_count", StallCount, 5);
      check_eq("miss_nostall", StallF, 0);
      tick();

      // Watchdog: 7-cycle runs never time out
      for (int k = 0; k < 2; k++) begin
         cache_miss(7);
         tick();
      end
      check_eq("wd_short", StallTimeout, 0);
      check_eq("wd_short_count", StallCount, 19);
      cache_miss(7);
      check_eq("wd_seven", StallTimeout, 0);
      cache_miss(1);
      check_eq("wd_eight", StallTimeout, 1);
      tick();
      check_eq("wd_sticky", StallTimeout, 1);
      check_eq("wd_count", StallCount, 27);
      cache_miss(6);
      check_eq("count_sat", StallCount, 31);

      // Reset in mid-operation
      RESETn = 0; tick(); RESETn = 1;
      check_eq("rst2_timeout", StallTimeout, 0);
      issue(4); tick();
      issue(5); tick();
      set_idle();
      cache_miss(10);
      check_eq("pre_rst_pending", Pending, 12'h030);
      check_eq("pre_rst_count", StallCount, 10);
      RESETn = 0; issue(1); RA1E = 3; WA3M = 3; RegWriteM = 1; #1;
      check_eq("rst_comb_fwd", ForwardAE, 2'b10);
      tick();
      RESETn = 1; set_idle(); #1;
      check_eq("mid_rst_pending", Pending, 12'h000);
      check_eq("mid_rst_count", StallCount, 0);
      check_eq("mid_rst_outs", {StallF, FlushE, ForwardAE, StallTimeout}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
